// File: rtl/div_unit_if.sv
// Divider request/response bundle between the E stage and the divide unit.
// Latency: none, wires only.
// Backpressure: the slave side drives stall_div back toward the hazard unit.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               stall_div;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, annul, a, b,
    input  stall_div, ready, result
  );

  modport slave (
    input  start, signed_div, annul, a, b,
    output stall_div, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) for the execute stage, result is {rem, quo}.
// Latency: accept at cycle 0, WIDTH busy steps, ready pulse in cycle WIDTH+1.
// Backpressure: stall_div holds F/D/E from accept through the last busy step, low in DONE.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dvsr;
  logic [WIDTH-1:0]     r_a_orig;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_div0;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_accept;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_q_fix;
  logic [WIDTH-1:0]     w_r_fix;
  logic [2*WIDTH-1:0]   w_final;
  logic                 w_done_ok;

  // Operand conditioning: divide magnitudes, signs are restored at the end.
  assign w_accept = (r_state == IDLE) & bus.start & ~bus.annul;
  assign w_a_neg  = bus.signed_div & bus.a[WIDTH-1];
  assign w_b_neg  = bus.signed_div & bus.b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;

  // One restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvsr};

  // Sign correction; divide-by-zero bypasses it and returns the raw dividend.
  assign w_q_fix  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix  = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  assign w_final  = r_div0 ? {r_a_orig, {WIDTH{1'b1}}} : {w_r_fix, w_q_fix};

  // DONE presents the fresh result combinationally so a same-cycle annul can still squash it.
  assign w_done_ok     = (r_state == DONE) & ~bus.annul;
  assign bus.ready     = w_done_ok;
  assign bus.result    = w_done_ok ? w_final : r_result;
  assign bus.stall_div = ~rst & (w_accept | ((r_state == BUSY) & ~bus.annul));

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_a_orig <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (bus.b == '0);
            r_a_orig <= bus.a;
            r_quo    <= w_a_mag;
            r_dvsr   <= w_b_mag;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (bus.annul) begin
            r_state <= IDLE;
          end else begin
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
            end else begin
              r_rem <= w_rem_sh[WIDTH-1:0];
            end
            r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (!bus.annul) begin
            r_result <= w_final;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model plus cycle-level expectations.
// Drives inputs 1 time unit after the rising edge and samples on the falling edge.
module tb_div_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;

  div_unit_if #(.WIDTH(32)) dif ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: 64-bit signed/unsigned division, remainder follows the dividend.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input bit sg);
    longint     sx;
    longint     sy;
    logic [63:0] q;
    logic [63:0] r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (sg) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end
    q = 64'(sx / sy);
    r = 64'(sx % sy);
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle-level expectation state: is an op in flight, when was it accepted, what it should give.
  bit          m_busy;
  int          m_acc;
  logic [63:0] m_exp;
  logic [63:0] m_last;

  // Compare process: every falling edge checks stall/ready/result against the model.
  always @(negedge clk) begin
    bit          es;
    bit          er;
    logic [63:0] eres;
    int          rel;
    if (rst) begin
      chk("rst_stall", 64'(dif.stall_div), 64'd0);
      chk("rst_ready", 64'(dif.ready), 64'd0);
      chk("rst_result", dif.result, 64'd0);
      m_busy = 1'b0;
      m_last = 64'd0;
    end else begin
      rel  = cyc - m_acc;
      es   = 1'b0;
      er   = 1'b0;
      eres = m_last;
      if (!m_busy) begin
        es = dif.start & ~dif.annul;
      end else if (rel <= 32) begin
        es = ~dif.annul;
      end else begin
        er = ~dif.annul;
        if (!dif.annul) eres = m_exp;
      end
      chk("stall_div", 64'(dif.stall_div), 64'(es));
      chk("ready", 64'(dif.ready), 64'(er));
      chk("result", dif.result, eres);
      if (m_busy) begin
        if (rel <= 32) begin
          if (dif.annul) m_busy = 1'b0;
        end else begin
          m_busy = 1'b0;
          if (!dif.annul) m_last = m_exp;
        end
      end else if (dif.start && !dif.annul) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_exp  = model(dif.a, dif.b, dif.signed_div);
      end
    end
    cyc++;
  end

  // Issue one divide at the current cycle (cycle 0) and watch for ready; operands are
  // perturbed after accept to show they are not re-sampled.
  task automatic do_div(input string name, input logic [31:0] xa, input logic [31:0] xb,
                        input bit sg, input logic [63:0] exp, input bit keep);
    bit got;
    int rdy_c;
    int n_stall;
    got     = 1'b0;
    rdy_c   = -1;
    n_stall = 0;
    dif.start      = 1'b1;
    dif.a          = xa;
    dif.b          = xb;
    dif.signed_div = sg;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.stall_div) n_stall++;
      if (dif.ready && !got) begin
        got   = 1'b1;
        rdy_c = c;
        chk({name, "_res"}, dif.result, exp);
      end
      @(posedge clk);
      #1;
      if (c == 3) begin
        dif.a = ~xa;
        dif.b = xb ^ 32'h5;
      end
      if (got) break;
    end
    if (!got) chk({name, "_timeout"}, 64'd0, 64'd1);
    chk({name, "_rdy_cyc"}, 64'(rdy_c), 64'd33);
    chk({name, "_stall_cnt"}, 64'(n_stall), 64'd33);
    if (!keep) dif.start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    m_busy = 1'b0;
    m_acc  = 0;
    m_exp  = 64'd0;
    m_last = 64'd0;
    rst            = 1'b1;
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.annul      = 1'b0;
    dif.a          = 32'd0;
    dif.b          = 32'd0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Pin the reference model with hand-computed values.
    chk("model_divu", model(32'd100, 32'd7, 1'b0), {32'h0000_0002, 32'h0000_000E});
    chk("model_div_neg", model(32'hFFFF_FF9C, 32'd7, 1'b1), {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    chk("model_ovf", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0000_0000, 32'h8000_0000});
    chk("model_div0", model(32'h1234, 32'd0, 1'b0), {32'h0000_1234, 32'hFFFF_FFFF});

    // Directed vectors.
    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 1'b0);
    do_div("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);
    do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 1'b0);
    do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 1'b0);
    do_div("divu_by0", 32'h1234, 32'd0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, 1'b0);
    do_div("div_by0", 32'hFFFF_FF9C, 32'd0, 1'b1, {32'hFFFF_FF9C, 32'hFFFF_FFFF}, 1'b0);
    do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0);

    // Annul in IDLE blocks accept.
    dif.start = 1'b1;
    dif.annul = 1'b1;
    dif.a     = 32'd50;
    dif.b     = 32'd5;
    #1 chk("idle_annul_stall", 64'(dif.stall_div), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.annul = 1'b0;
    @(posedge clk);
    #1;

    // Annul in BUSY at cycle 10: stall drops immediately, no ready, result held.
    dif.start = 1'b1;
    dif.a     = 32'd50;
    dif.b     = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    dif.annul = 1'b1;
    #1 chk("busy_annul_stall", 64'(dif.stall_div), 64'd0);
    @(posedge clk);
    #1;
    dif.annul = 1'b0;
    dif.start = 1'b0;
    @(posedge clk);
    #1;
    do_div("after_annul", 32'd1000, 32'd10, 1'b0, {32'h0000_0000, 32'h0000_0064}, 1'b0);

    // Annul in DONE: ready suppressed, result keeps the previous value.
    dif.start = 1'b1;
    dif.a     = 32'd77;
    dif.b     = 32'd7;
    repeat (33) @(posedge clk);
    #1;
    dif.annul = 1'b1;
    #1;
    chk("done_annul_ready", 64'(dif.ready), 64'd0);
    chk("done_annul_result", dif.result, {32'h0000_0000, 32'h0000_0064});
    @(posedge clk);
    #1;
    dif.annul = 1'b0;
    dif.start = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-operation.
    dif.start = 1'b1;
    dif.a     = 32'd1000;
    dif.b     = 32'd3;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_stall", 64'(dif.stall_div), 64'd0);
    chk("arst_ready", 64'(dif.ready), 64'd0);
    chk("arst_result", dif.result, 64'd0);
    dif.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    do_div("divu_9_3", 32'd9, 32'd3, 1'b0, {32'h0000_0000, 32'h0000_0003}, 1'b0);

    // Back-to-back: second accepted in the cycle right after DONE.
    do_div("b2b_first", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 1'b1);
    do_div("b2b_second", 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit signed/unsigned integer divider for the execute stage of the five-stage MIPS pipeline. It drives the divide-stall request that the hazard unit consumes as `stall_divE`. While a division is in progress, that request holds F, D and E and lets M/W drain. When the division completes, it presents the quotient/remainder pair for HI/LO write-back.

## Interface
Parameters:
- `WIDTH`, 32, operand width. Quotient and remainder are each `WIDTH` bits.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `start`  in  1  E-stage instruction is DIV/DIVU. Held high while the pipeline is stalled.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled at accept.
- `annul`  in  1  cancel the current or pending operation (exception/flush of E).
- `a`  in  WIDTH  dividend (rs value after E forwarding). Sampled at accept.
- `b`  in  WIDTH  divisor (rt value after E forwarding). Sampled at accept.
- `stall_div`  out  1  divide stall request; goes to hazard `stall_divE`.
- `ready`  out  1  one-cycle pulse; `result` is valid for the HI/LO write.
- `result`  out  2*WIDTH  {remainder (HI), quotient (LO)}.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE, with `start & ~annul`:
  - latch sign flags and |a|, |b| (signed) or a, b (unsigned); zero the partial remainder; count = 0.
  - next state BUSY.
- BUSY: one restoring step per cycle.
  - Shift {rem, quo} left 1; trial = rem − divisor over WIDTH+1 bits.
  - If non-negative, rem = trial and quo LSB = 1.
  - count increments. After step WIDTH (count == WIDTH−1 completes), next state DONE.
- DONE:
  - apply sign correction and load `result`; `ready` = 1.
  - next state IDLE unconditionally.
- Sign rules (signed only):
  - quotient negated if a[MSB] ^ b[MSB];
  - remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps).
- Divide by zero (b == 0, either mode):
  - same latency;
  - result = {a, 32'hFFFFFFFF} (remainder = original a, quotient = all ones);
  - no sign correction.
- `stall_div` = (IDLE & `start` & ~`annul`) | BUSY. It is combinational and is 0 in DONE.
- `annul`:
  - in BUSY it returns the FSM to IDLE next edge, and `stall_div` drops in the same cycle.
  - in DONE it suppresses `ready` and leaves `result` unchanged.
  - in IDLE it blocks accept.
- `result` holds its value until the next non-annulled DONE.
- Reset values (async, mid-operation included):
  - state IDLE;
  - `result` = 0;
  - `ready` = 0;
  - `stall_div` = 0 while `rst` is high;
  - internal counters/registers 0.

## Timing
- Accept at cycle 0 (IDLE, `start` high) and BUSY for cycles 1..WIDTH.
- DONE at cycle WIDTH+1 (33 for WIDTH = 32): `ready` high and `result` valid in that cycle.
- `stall_div` is high for cycles 0..WIDTH (33 cycles) and low in DONE, so E advances at the end of DONE.
- Back-to-back divides:
  - the next instruction reaches E at cycle WIDTH+2;
  - FSM is IDLE there and accepts immediately, with no bubble cycle lost.
- `start` remaining high during DONE does not restart; only IDLE accepts.
- Operands are not re-sampled during BUSY. Forwarding changes after accept have no effect.

## Test plan
- DIVU 100 / 7 → `ready` at cycle 33; `result` = {0x00000002, 0x0000000E}; `stall_div` high exactly 33 cycles.
- DIV −100 (0xFFFFFF9C) / 7 → quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2).
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero: DIVU 0x1234 / 0 → result {0x00001234, 0xFFFFFFFF} at cycle 33.
- `annul` at cycle 10 → `stall_div` low the same cycle, no `ready`, `result` keeps its prior value. A fresh `start` at cycle 12 completes normally at cycle 45.
- `rst` pulsed at cycle 20 (asynchronous, between edges) → `stall_div`, `ready` and `result` go 0 immediately. After release, DIVU 9 / 3 → {0, 3} 33 cycles after accept. Two back-to-back divides give `ready` at cycles 33 and 67.
